// File: rtl/rc4_breaker_pkg.sv
// Shared types and default sizing for the RC4 key-search datapath.
package rc4_breaker_pkg;

   localparam int unsigned DEF_NUM_CORES = 4;
   localparam int unsigned DEF_KEY_WIDTH = 24;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      ISSUE,
      SETTLE,
      DRAIN,
      FOUND,
      EXHAUSTED
   } dispatch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
   import rc4_breaker_pkg::*;
#(
   parameter int unsigned N = DEF_NUM_CORES
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic                 any
);

   localparam int unsigned PW = $clog2(N);

   logic [PW-1:0] idx;

   // Walk the ring starting at ptr; the first hit locks out later candidates.
   always_comb begin
      gnt = '0;
      any = 1'b0;
      idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = PW'((32'(ptr) + k) % N);
         if (!any && req[idx]) begin
            gnt[idx] = 1'b1;
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_dispatch_arbiter.sv
// Hands LFSR keys to RC4 decrypt cores round-robin and stops on success or exhaustion.
// Optional grant counter on keys_issued when KEY_DISPATCH_STATS_EN is defined.
module key_dispatch_arbiter
   import rc4_breaker_pkg::*;
#(
   parameter int unsigned NUM_CORES = DEF_NUM_CORES,
   parameter int unsigned KEY_WIDTH = DEF_KEY_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [KEY_WIDTH-1:0] gen_key,
   input  logic                 gen_available,
   input  logic                 gen_finished,
   output logic                 gen_read,
   input  logic [NUM_CORES-1:0] core_req,
   input  logic [NUM_CORES-1:0] core_done,
   input  logic [NUM_CORES-1:0] core_found,
   output logic [NUM_CORES-1:0] core_grant,
   output logic [KEY_WIDTH-1:0] core_key,
   output logic                 stop_all,
   output logic                 done,
   output logic                 success,
   output logic [KEY_WIDTH-1:0] found_key,
   output logic [KEY_WIDTH:0]   keys_issued
);

   localparam int unsigned PW = $clog2(NUM_CORES);
   localparam int unsigned CW = KEY_WIDTH + 1;

   dispatch_state_t state, state_nxt;

   logic [NUM_CORES-1:0] busy;
   logic [PW-1:0]        ptr;
   logic [PW-1:0]        win;
   logic [KEY_WIDTH-1:0] key_tbl [NUM_CORES];

   logic [NUM_CORES-1:0] req_eff;
   logic [NUM_CORES-1:0] arb_gnt;
   logic                 arb_any;
   logic [PW-1:0]        win_idx;
   logic [NUM_CORES-1:0] live_found;
   logic                 found_hit;
   logic [KEY_WIDTH-1:0] found_key_nxt;
   logic                 issue_go;

   assign req_eff = core_req & ~busy;

   rr_arbiter #(.N(NUM_CORES)) u_rr (
      .req (req_eff),
      .ptr (ptr),
      .gnt (arb_gnt),
      .any (arb_any)
   );

   // Winner index and found resolution (descending walk lets the lowest index win).
   always_comb begin
      win_idx       = '0;
      live_found    = core_found & busy;
      found_key_nxt = '0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
         if (arb_gnt[i]) win_idx = PW'(i);
      end
      for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
         if (live_found[i]) found_key_nxt = key_tbl[i];
      end
   end

   assign found_hit = (state inside {ARB, ISSUE, SETTLE, DRAIN}) && (|live_found);

   // Next-state logic; a found pulse preempts grants, drain and exhaustion.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (start) state_nxt = ARB;
         ARB: begin
            if (found_hit)                       state_nxt = FOUND;
            else if (gen_finished)               state_nxt = DRAIN;
            else if (gen_available && arb_any)   state_nxt = ISSUE;
         end
         ISSUE:     state_nxt = found_hit ? FOUND : SETTLE;
         SETTLE: begin
            if (found_hit)         state_nxt = FOUND;
            else if (gen_finished) state_nxt = DRAIN;
            else                   state_nxt = ARB;
         end
         DRAIN: begin
            if (found_hit)         state_nxt = FOUND;
            else if (busy == '0)   state_nxt = EXHAUSTED;
         end
         FOUND:     state_nxt = FOUND;
         EXHAUSTED: state_nxt = EXHAUSTED;
         default:   state_nxt = IDLE;
      endcase
   end

   assign issue_go = (state == ARB) && (state_nxt == ISSUE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Grant outputs are registered so they line up exactly with the ISSUE cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_grant <= '0;
         core_key   <= '0;
         gen_read   <= 1'b0;
         win        <= '0;
         done       <= 1'b0;
         success    <= 1'b0;
         stop_all   <= 1'b0;
         found_key  <= '0;
      end else begin
         core_grant <= issue_go ? arb_gnt : '0;
         core_key   <= issue_go ? gen_key : '0;
         gen_read   <= issue_go;
         if (issue_go) win <= win_idx;
         done       <= (state_nxt inside {FOUND, EXHAUSTED});
         stop_all   <= (state_nxt inside {FOUND, EXHAUSTED});
         success    <= (state_nxt == FOUND);
         if (found_hit) found_key <= found_key_nxt;
      end
   end

   // Per-core bookkeeping: busy mask, held key, and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy <= '0;
         ptr  <= '0;
         for (int i = 0; i < int'(NUM_CORES); i++) key_tbl[i] <= '0;
      end else begin
         busy <= (busy & ~(core_done | core_found)) | core_grant;
         if (state == ISSUE) begin
            key_tbl[win] <= core_key;
            ptr <= (32'(win) == NUM_CORES - 1) ? '0 : PW'(32'(win) + 1);
         end
      end
   end

`ifdef KEY_DISPATCH_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                             keys_issued <= '0;
      else if (issue_go && (keys_issued != '1)) keys_issued <= keys_issued + CW'(1);
   end
`else
   assign keys_issued = '0;
`endif

endmodule
